// File: rtl/lsnorm_seq_if.sv
// Start/busy/done bundle between the FPU microsequencer and the left-shift normalizer.
// The master raises start with the operand; the slave reports busy, done and the result.
interface lsnorm_seq_if #(
  parameter int W  = 64,
  parameter int CW = 7
);
  logic          start;
  logic [W-1:0]  mant_in;
  logic          ovf_in;
  logic          stin;
  logic [CW-1:0] shlim;
  logic          busy;
  logic          done;
  logic [W-1:0]  mant_out;
  logic [CW-1:0] shcnt;
  logic          exp_inc;
  logic          zero;
  logic          sticky;

  modport master (
    output start, mant_in, ovf_in, stin, shlim,
    input  busy, done, mant_out, shcnt, exp_inc, zero, sticky
  );

  modport slave (
    input  start, mant_in, ovf_in, stin, shlim,
    output busy, done, mant_out, shcnt, exp_inc, zero, sticky
  );
endinterface

// File: rtl/lsnorm_seq.sv
// Sequential left-shift normalizer: right-normalizes on carry-out, else shifts left by STEP or 1 per cycle.
// Finishes at MSB set or shift limit; start is ignored while busy, result held until next accepted start.
module lsnorm_seq #(
  parameter int W    = 64,
  parameter int CW   = 7,
  parameter int STEP = 8
) (
  input  logic       clk,
  input  logic       reset,
  lsnorm_seq_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NORM = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CW:0] STEP_C = (CW+1)'(STEP);

  state_t        r_state, w_state_nxt;
  logic [W-1:0]  r_mant, w_mant_nxt;
  logic [CW-1:0] r_shcnt, w_shcnt_nxt;
  logic [CW-1:0] r_shlim, w_shlim_nxt;
  logic          r_exp_inc, w_exp_inc_nxt;
  logic          r_zero, w_zero_nxt;
  logic          r_sticky, w_sticky_nxt;

  logic          w_msb;
  logic          w_top_zero;
  logic [CW:0]   w_cnt_step;
  logic          w_step_ok;
  logic          w_at_limit;

  assign w_msb      = r_mant[W-1];
  assign w_top_zero = (r_mant[W-1 -: STEP] == '0);
  // One extra bit so shcnt+STEP cannot wrap before the compare against the limit.
  assign w_cnt_step = {1'b0, r_shcnt} + STEP_C;
  assign w_step_ok  = (w_cnt_step <= {1'b0, r_shlim});
  assign w_at_limit = (r_shcnt == r_shlim);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_mant_nxt    = r_mant;
    w_shcnt_nxt   = r_shcnt;
    w_shlim_nxt   = r_shlim;
    w_exp_inc_nxt = r_exp_inc;
    w_zero_nxt    = r_zero;
    w_sticky_nxt  = r_sticky;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_shlim_nxt = bus.shlim;
          w_shcnt_nxt = '0;
          if (bus.ovf_in) begin
            w_mant_nxt    = {1'b1, bus.mant_in[W-1:1]};
            w_sticky_nxt  = bus.stin | bus.mant_in[0];
            w_exp_inc_nxt = 1'b1;
            w_zero_nxt    = 1'b0;
            w_state_nxt   = S_DONE;
          end else if (bus.mant_in == '0) begin
            w_mant_nxt    = '0;
            w_sticky_nxt  = bus.stin;
            w_exp_inc_nxt = 1'b0;
            w_zero_nxt    = 1'b1;
            w_state_nxt   = S_DONE;
          end else begin
            w_mant_nxt    = bus.mant_in;
            w_sticky_nxt  = bus.stin;
            w_exp_inc_nxt = 1'b0;
            w_zero_nxt    = 1'b0;
            w_state_nxt   = S_NORM;
          end
        end
      end
      S_NORM: begin
        if (w_msb || w_at_limit) begin
          w_state_nxt = S_DONE;
        end else if (w_top_zero && w_step_ok) begin
          w_mant_nxt  = r_mant << STEP;
          w_shcnt_nxt = r_shcnt + STEP_C[CW-1:0];
        end else begin
          w_mant_nxt  = r_mant << 1;
          w_shcnt_nxt = r_shcnt + CW'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mant    <= '0;
      r_shcnt   <= '0;
      r_shlim   <= '0;
      r_exp_inc <= 1'b0;
      r_zero    <= 1'b0;
      r_sticky  <= 1'b0;
    end else begin
      r_mant    <= w_mant_nxt;
      r_shcnt   <= w_shcnt_nxt;
      r_shlim   <= w_shlim_nxt;
      r_exp_inc <= w_exp_inc_nxt;
      r_zero    <= w_zero_nxt;
      r_sticky  <= w_sticky_nxt;
    end
  end

  assign bus.busy     = (r_state != S_IDLE);
  assign bus.done     = (r_state == S_DONE);
  assign bus.mant_out = r_mant;
  assign bus.shcnt    = r_shcnt;
  assign bus.exp_inc  = r_exp_inc;
  assign bus.zero     = r_zero;
  assign bus.sticky   = r_sticky;

  // The shift count is bounded by the captured limit for the whole operation.
  a_shcnt_bound: assert property (@(posedge clk) disable iff (reset)
    (r_state == S_IDLE) || (r_shcnt <= r_shlim));

endmodule
